ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: maximum number of consecutive cycles the core may wait during a host burst before the burst is broken.
REQ-002 Parameter ADDR_W, default 8: address width, matching the 256x8 data RAM.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port reset  in  1  reset, asynchronous, active-high.
REQ-005 Ports core_req/core_we  in  1 each  core access request and write qualifier.
REQ-006 Ports core_addr  in  ADDR_W, and core_wdata  in  8  core access address and write data.
REQ-007 Ports core_gnt  out  1  core access accepted this cycle.
REQ-008 Ports core_rvalid  out  1, and core_rdata  out  8  core read return.
REQ-009 Ports host_req/host_we  in  1 each, host_addr  in  ADDR_W, host_wdata  in  8  host (loader/debug) request.
REQ-010 Port host_burst_len  in  4  number of extra beats the host requests to lock, sampled on the first host grant.
REQ-011 Ports host_gnt  out  1, host_rvalid  out  1, host_rdata  out  8  host grant and read return.
REQ-012 Ports ram_we  out  1, ram_addr  out  ADDR_W, ram_wdata  out  8, ram_rdata  in  8  shared RAM port (asynchronous read, synchronous write).
REQ-013 Port owner  out  2  current lock state for debug: 0 = none, 1 = core, 2 = host burst.

Function
REQ-014 A transfer occurs in any cycle where req and gnt are both high for one requester; at most one gnt is high per cycle.
REQ-015 The gnt signals are combinational from the req inputs and registered state: zero-latency grant, no request buffering.
REQ-016 When a requester is granted, ram_addr, ram_wdata and ram_we follow that requester's inputs combinationally.
REQ-017 When nobody is granted, ram_we is 0 and ram_addr/ram_wdata are 0.
REQ-018 Read latency is one cycle: after a granted read (we = 0), that requester's rvalid is high for exactly one cycle, with rdata equal to ram_rdata captured at the grant edge.
REQ-019 rdata holds its last value while rvalid is low.
REQ-020 A granted write produces no rvalid.
REQ-021 FSM states: IDLE, SINGLE, BURST.
REQ-022 In IDLE and SINGLE, contention is resolved round-robin using last_owner: the requester not granted last wins a tie, and a sole requester always wins.
REQ-023 Transition to BURST: on a host grant from IDLE/SINGLE with host_burst_len > 0, load beat_cnt = host_burst_len.
REQ-024 In BURST, only the host is granted; beat_cnt decrements on each host transfer.
REQ-025 BURST returns to SINGLE after the transfer with beat_cnt = 1, or immediately when host_req drops.
REQ-026 In BURST, wait_cnt increments each cycle core_req is high and saturates at STARVE_LIMIT.
REQ-027 When wait_cnt = STARVE_LIMIT, the burst is broken: that cycle grants the core, state goes to SINGLE, and beat_cnt is cleared.
REQ-028 wait_cnt clears on any core grant and whenever core_req is low.
REQ-029 IDLE goes to SINGLE when any req is high; SINGLE goes to IDLE when no req is high.
REQ-030 last_owner updates on every transfer.
REQ-031 A new host burst is not allowed to start in the cycle immediately after a broken burst if core_req is high (core gets priority for one beat).
REQ-032 owner reflects the state: IDLE → 0; SINGLE → 1 or 2 per last_owner; BURST → 2.

Reset
REQ-033 Reset forces the following: state IDLE, last_owner = host (the core wins the first tie), beat_cnt = 0, wait_cnt = 0, both rvalid = 0, both rdata = 0.
REQ-034 Reset asserted mid-burst or mid-read discards the pending rvalid; no RAM write occurs while reset is high.

Structure
REQ-035 The package limb_pkg holds the state enum (IDLE/SINGLE/BURST), the owner encoding and the default STARVE_LIMIT.
REQ-036 The block is flat apart from one sub-module, rr_pick, a 2-way round-robin tie-break function block.

Verification
REQ-037 Reset, then core read addr 0x10 with RAM[0x10] = 0xA5 → core_gnt same cycle; core_rvalid = 1 and core_rdata = 0xA5 next cycle.
REQ-038 core_req and host_req both high for 4 cycles, single beats → grants alternate core, host, core, host.
REQ-039 Host write burst with host_burst_len = 3 at addr 0x20..0x23 while core idle → 4 consecutive host_gnt; owner = 2 for beats 2–4; RAM holds the written data.
REQ-040 Host burst_len = 15 with core_req held high, STARVE_LIMIT = 8 → core_gnt on the 9th waiting cycle; state returns to SINGLE.
REQ-041 Host drops req mid-burst (after 2 beats of 5) → state SINGLE next cycle; a pending core_req is granted.
REQ-042 Reset asserted the cycle after a granted read → core_rvalid stays 0; owner = 0.

Source files
------------

// File: rtl/limb_pkg.sv
// Shared types for the RAM arbiter: FSM states, lock-owner encoding and
// the default starvation limit.
package limb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin tie-break: a sole requester always wins, and on a tie
// the requester that was not served last wins.
module rr_pick (
  input  logic req_core,
  input  logic req_host,
  input  logic last_host,
  output logic pick_core,
  output logic pick_host
);

  always_comb begin
    pick_core = req_core & (~req_host | last_host);
    pick_host = req_host & (~req_core | ~last_host);
  end

endmodule

// File: rtl/ram_arbiter.sv
// Zero-latency arbiter sharing one RAM port between the core and a host
// loader, with locked host bursts that the core can break after starving.
module ram_arbiter
  import limb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [7:0]        core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic [3:0]        host_burst_len,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        owner
);

  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              brk_q, brk_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [7:0]        core_rdata_q, core_rdata_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic              rr_core, rr_host, last_host, starve;

  assign last_host = (last_owner_q == OWN_HOST);
  assign starve    = (wait_cnt_q == WAIT_MAX) & core_req;

  rr_pick u_rr_pick (
    .req_core  (core_req),
    .req_host  (host_req),
    .last_host (last_host),
    .pick_core (rr_core),
    .pick_host (rr_host)
  );

  // Grants are gated by reset so no RAM write can slip out while it is high.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        BURST: begin
          core_gnt = starve;
          host_gnt = ~starve & host_req;
        end
        default: begin
          if (brk_q && core_req) begin
            core_gnt = 1'b1;
          end else begin
            core_gnt = rr_core;
            host_gnt = rr_host;
          end
        end
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (core_gnt) begin
      ram_we    = core_we;
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
    end else if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    wait_cnt_d   = '0;
    brk_d        = 1'b0;
    last_owner_d = last_owner_q;

    if (core_gnt)      last_owner_d = OWN_CORE;
    else if (host_gnt) last_owner_d = OWN_HOST;

    case (state_q)
      BURST: begin
        if (core_gnt) begin
          state_d    = SINGLE;
          beat_cnt_d = '0;
          brk_d      = 1'b1;
        end else if (!host_req || beat_cnt_q == 4'd1) begin
          state_d    = SINGLE;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q - 4'd1;
        end
        if (core_req && !core_gnt)
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
      end
      default: begin
        if (host_gnt && host_burst_len != 4'd0) begin
          state_d    = BURST;
          beat_cnt_d = host_burst_len;
        end else if (core_req || host_req) begin
          state_d = SINGLE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    core_rvalid_d = core_gnt & ~core_we;
    host_rvalid_d = host_gnt & ~host_we;
    core_rdata_d  = core_rvalid_d ? ram_rdata : core_rdata_q;
    host_rdata_d  = host_rvalid_d ? ram_rdata : host_rdata_q;
  end

  always_comb begin
    case (state_q)
      IDLE:    owner = OWN_NONE;
      BURST:   owner = OWN_HOST;
      default: owner = (last_owner_q == OWN_CORE) ? OWN_CORE : OWN_HOST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_owner_q  <= OWN_HOST;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      brk_q         <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      last_owner_q  <= last_owner_d;
      beat_cnt_q    <= beat_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      brk_q         <= brk_d;
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a 256x8 RAM model on the shared port and
// hand-computed expectations for grants, read returns, bursts and resets.
module tb_ram_arbiter;

  logic       clk, reset;
  logic       core_req, core_we, core_gnt, core_rvalid;
  logic [7:0] core_addr, core_wdata, core_rdata;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic [3:0] host_burst_len;
  logic       ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0] owner;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.STARVE_LIMIT(8), .ADDR_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_gnt       (core_gnt),
    .core_rvalid    (core_rvalid),
    .core_rdata     (core_rdata),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_burst_len (host_burst_len),
    .host_gnt       (host_gnt),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .owner          (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    host_burst_len = 4'd0;
  endtask

  task automatic core_rd(input logic [7:0] a);
    core_req = 1'b1; core_we = 1'b0; core_addr = a; core_wdata = 8'h00;
  endtask

  task automatic host_acc(input logic we, input logic [7:0] a, input logic [7:0] d,
                          input logic [3:0] len);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; host_burst_len = len;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    // A write request held during reset must never reach the RAM.
    host_acc(1'b1, 8'h10, 8'hEE, 4'd0);
    sample();
    check("rst_ram_we",      8'(ram_we),      8'd0);
    check("rst_host_gnt",    8'(host_gnt),    8'd0);
    check("rst_owner",       8'(owner),       8'd0);
    check("rst_core_rvalid", 8'(core_rvalid), 8'd0);
    check("rst_host_rvalid", 8'(host_rvalid), 8'd0);
    check("rst_core_rdata",  core_rdata,      8'h00);
    check("rst_host_rdata",  host_rdata,      8'h00);
    idle();
    reset = 1'b0;
    sample();
    check("idle_owner", 8'(owner), 8'd0);

    // Host single write RAM[0x10] = 0xA5.
    next_cycle(); host_acc(1'b1, 8'h10, 8'hA5, 4'd0); sample();
    check("hw_host_gnt",  8'(host_gnt), 8'd1);
    check("hw_core_gnt",  8'(core_gnt), 8'd0);
    check("hw_ram_we",    8'(ram_we),   8'd1);
    check("hw_ram_addr",  ram_addr,     8'h10);
    check("hw_ram_wdata", ram_wdata,    8'hA5);
    next_cycle(); idle(); sample();
    check("hw_no_rvalid",   8'(host_rvalid), 8'd0);
    check("hw_owner",       8'(owner),       8'd2);
    check("nogrant_we",     8'(ram_we),      8'd0);
    check("nogrant_addr",   ram_addr,        8'h00);

    // Core read of 0x10: zero-latency grant, data one cycle later.
    next_cycle(); core_rd(8'h10); sample();
    check("cr_core_gnt", 8'(core_gnt), 8'd1);
    check("cr_ram_addr", ram_addr,     8'h10);
    check("cr_ram_we",   8'(ram_we),   8'd0);
    next_cycle(); idle(); sample();
    check("cr_rvalid", 8'(core_rvalid), 8'd1);
    check("cr_rdata",  core_rdata,      8'hA5);
    check("cr_owner",  8'(owner),       8'd1);
    next_cycle(); sample();
    check("cr_rvalid_drop", 8'(core_rvalid), 8'd0);
    check("cr_rdata_hold",  core_rdata,      8'hA5);
    check("cr_idle_owner",  8'(owner),       8'd0);

    // Host write RAM[0x30] = 0x3C leaves last_owner = host.
    next_cycle(); host_acc(1'b1, 8'h30, 8'h3C, 4'd0); sample();
    check("hw2_host_gnt", 8'(host_gnt), 8'd1);

    // Both requesting single reads: core, host, core, host.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); core_rd(8'h10); host_acc(1'b0, 8'h30, 8'h00, 4'd0); sample();
      check($sformatf("rr_core_gnt%0d", i), 8'(core_gnt), (i % 2 == 0) ? 8'd1 : 8'd0);
      check($sformatf("rr_host_gnt%0d", i), 8'(host_gnt), (i % 2 == 1) ? 8'd1 : 8'd0);
      if (i == 1) check("rr_core_rdata", core_rdata, 8'hA5);
      if (i == 2) check("rr_host_rdata", host_rdata, 8'h3C);
      if (i == 2) check("rr_host_rvalid", 8'(host_rvalid), 8'd1);
    end
    next_cycle(); idle(); sample();
    check("rr_end_owner", 8'(owner), 8'd2);

    // Host write burst of 4 beats to 0x20..0x23.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); host_acc(1'b1, 8'h20 + 8'(i), 8'h50 + 8'(i), 4'd3); sample();
      check($sformatf("bw_host_gnt%0d", i), 8'(host_gnt), 8'd1);
      check($sformatf("bw_owner%0d", i), 8'(owner), (i == 0) ? 8'd0 : 8'd2);
    end
    next_cycle(); idle(); sample();
    check("bw_end_gnt",   8'(host_gnt), 8'd0);
    check("bw_end_owner", 8'(owner),    8'd2);

    // Read the burst data back through the core.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i < 4) core_rd(8'h20 + 8'(i)); else idle();
      sample();
      if (i > 0) begin
        check($sformatf("bw_rb_valid%0d", i - 1), 8'(core_rvalid), 8'd1);
        check($sformatf("bw_rb_data%0d", i - 1),  core_rdata,      8'h50 + 8'(i - 1));
      end
    end
    next_cycle(); sample();

    // Starvation: 15-beat host burst, core waits from the first BURST cycle.
    next_cycle(); host_acc(1'b0, 8'h20, 8'h00, 4'd15); sample();
    check("st_first_host_gnt", 8'(host_gnt), 8'd1);
    for (int k = 1; k <= 9; k++) begin
      next_cycle(); core_rd(8'h21); sample();
      check($sformatf("st_core_gnt%0d", k), 8'(core_gnt), (k == 9) ? 8'd1 : 8'd0);
      check($sformatf("st_host_gnt%0d", k), 8'(host_gnt), (k == 9) ? 8'd0 : 8'd1);
    end
    next_cycle(); sample();
    check("st_brk_core_gnt", 8'(core_gnt),    8'd1);
    check("st_brk_host_gnt", 8'(host_gnt),    8'd0);
    check("st_brk_owner",    8'(owner),       8'd1);
    check("st_brk_rvalid",   8'(core_rvalid), 8'd1);
    check("st_brk_rdata",    core_rdata,      8'h51);
    next_cycle(); sample();
    check("st_after_host_gnt", 8'(host_gnt), 8'd1);
    check("st_after_core_gnt", 8'(core_gnt), 8'd0);
    next_cycle(); idle(); sample();
    check("st_drop_host_gnt", 8'(host_gnt), 8'd0);
    next_cycle(); sample();

    // Host drops its request after 2 of 6 beats; pending core is served.
    next_cycle(); host_acc(1'b0, 8'h22, 8'h00, 4'd5); sample();
    check("dr_beat1_gnt", 8'(host_gnt), 8'd1);
    next_cycle(); core_rd(8'h23); sample();
    check("dr_beat2_host_gnt", 8'(host_gnt), 8'd1);
    check("dr_beat2_core_gnt", 8'(core_gnt), 8'd0);
    check("dr_beat2_owner",    8'(owner),    8'd2);
    next_cycle(); host_req = 1'b0; sample();
    check("dr_drop_host_gnt", 8'(host_gnt), 8'd0);
    check("dr_drop_core_gnt", 8'(core_gnt), 8'd0);
    next_cycle(); sample();
    check("dr_single_core_gnt", 8'(core_gnt), 8'd1);
    next_cycle(); idle(); sample();
    check("dr_rvalid", 8'(core_rvalid), 8'd1);
    check("dr_rdata",  core_rdata,      8'h53);
    check("dr_owner",  8'(owner),       8'd1);

    // Reset right after a granted read discards the return.
    next_cycle(); core_rd(8'h10); sample();
    check("rr_gnt_before_rst", 8'(core_gnt), 8'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    sample();
    check("rd_rst_rvalid", 8'(core_rvalid), 8'd0);
    check("rd_rst_owner",  8'(owner),       8'd0);
    check("rd_rst_rdata",  core_rdata,      8'h00);
    reset = 1'b0;
    next_cycle(); sample();
    check("post_rst_rvalid", 8'(core_rvalid), 8'd0);
    check("post_rst_owner",  8'(owner),       8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
